// File: rtl/wb_ext_mem_arbiter.sv
// Round-robin N-master Wishbone arbiter for the external memory port.
// Holds the grant for a whole cyc and aborts stalled transfers with err via a response watchdog.
module wb_ext_mem_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 27,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [DW/8-1:0]           s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int unsigned SW      = DW / 8;
  localparam int unsigned IW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic        WDOG_EN = (TIMEOUT != 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          wdog_q, wdog_d;

  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;
  logic [SW-1:0] sel_sel;
  logic          sel_we, sel_cyc, sel_stb;
  logic [2:0]    sel_cti;
  logic [1:0]    sel_bte;

  logic          rr_found;
  logic [IW-1:0] rr_pick;
  int unsigned   rr_dist, rr_best;

  logic any_rsp;
  logic abort;

  // Owner's request, zero when nothing is granted
  always_comb begin
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    sel_we  = 1'b0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_cti = '0;
    sel_bte = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        sel_adr = m_adr_i[k*AW +: AW];
        sel_dat = m_dat_i[k*DW +: DW];
        sel_sel = m_sel_i[k*SW +: SW];
        sel_we  = m_we_i[k];
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        sel_cti = m_cti_i[k*3 +: 3];
        sel_bte = m_bte_i[k*2 +: 2];
      end
    end
  end

  // Pick the requester closest after the previous owner, wrapping
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_best  = NUM_MASTERS;
    rr_dist  = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      rr_dist = (k + NUM_MASTERS - 1 - 32'(last_q)) % NUM_MASTERS;
      if (m_cyc_i[k] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_pick  = IW'(k);
        rr_found = 1'b1;
      end
    end
  end

  assign any_rsp = s_ack_i | s_err_i | s_rty_i;
  // A response arriving on the expiry cycle beats the abort
  assign abort   = WDOG_EN & (state_q == BUSY) & sel_stb & ~any_rsp & (wdog_q == CW'(TIMEOUT));

  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;
  assign s_sel_o = sel_sel;
  assign s_we_o  = sel_we;
  assign s_cti_o = sel_cti;
  assign s_bte_o = sel_bte;
  assign s_cyc_o = sel_cyc & ~abort;
  assign s_stb_o = sel_stb & ~abort;

  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i & s_stb_o}};
  assign m_rty_o   = grant_q & {NUM_MASTERS{s_rty_i & s_stb_o}};
  assign m_err_o   = grant_q & {NUM_MASTERS{(s_err_i & s_stb_o) | abort}};
  assign grant_o   = grant_q;
  assign timeout_o = abort;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = BUSY;
          grant_d = NUM_MASTERS'(1) << rr_pick;
          last_d  = rr_pick;
        end
      end
      BUSY: begin
        if (WDOG_EN && s_stb_o && !any_rsp) begin
          wdog_d = wdog_q + CW'(1);
        end
        if (!sel_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_ext_mem_arbiter.sv
// Randomized three-master traffic against a cycle-level reference of the arbiter's rules.
// A model process queues the expected outputs of each cycle; a negedge monitor pops and compares.
module tb_wb_ext_mem_arbiter;

  localparam int unsigned NM  = 3;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TO  = 16;
  localparam int          NTX = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wire  [NM*AW-1:0] m_adr_i;
  wire  [NM*DW-1:0] m_dat_i;
  wire  [NM*SW-1:0] m_sel_i;
  wire  [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
  wire  [NM*3-1:0]  m_cti_i;
  wire  [NM*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_dat_i = '0;
  logic             s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  wb_ext_mem_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NM-1:0] gnt;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] sdat;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [NM-1:0] rty;
    logic          to;
    logic [DW-1:0] mdat;
  } obs_t;

  obs_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic          fin = 1'b0;
  logic          rst_hit = 1'b0;
  logic          rst_cyc_obs = 1'b1, rst_stb_obs = 1'b1;
  logic [NM-1:0] rst_gnt_obs = '1;
  logic          all_done = 1'b0;
  logic [NM-1:0] done_v, hung_v;

  // Masters: random single/burst transfers, end a transfer on err/rty, drop out on reset
  for (genvar k = 0; k < NM; k++) begin : g_m
    logic          cyc, stb, we, done, hung;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;

    assign m_cyc_i[k]         = cyc;
    assign m_stb_i[k]         = stb;
    assign m_we_i[k]          = we;
    assign m_adr_i[k*AW +: AW] = adr;
    assign m_dat_i[k*DW +: DW] = dat;
    assign m_sel_i[k*SW +: SW] = sel;
    assign m_cti_i[k*3 +: 3]  = cti;
    assign m_bte_i[k*2 +: 2]  = bte;
    assign done_v[k]          = done;
    assign hung_v[k]          = hung;

    initial begin
      bit got, ok_ack, stop, aborted, restart;
      int beats;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
      cti = '0; bte = '0; done = 1'b0; hung = 1'b0; restart = 1'b0;
      wait (!rst);
      @(posedge clk); #1;
      for (int t = 0; t < NTX; t++) begin
        if (!restart) begin
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
        end
        restart = 1'b0;
        if (rst) begin
          wait (!rst);
          @(posedge clk); #1;
        end
        case ($urandom_range(0, 3))
          0, 1:    beats = 1;
          2:       beats = 4;
          default: beats = 8;
        endcase
        we  = 1'($urandom);
        bte = 2'($urandom);
        cyc = 1'b1;
        stb = 1'b1;
        stop = 1'b0;
        aborted = 1'b0;
        for (int b = 0; b < beats && !stop; b++) begin
          adr = AW'($urandom);
          dat = $urandom;
          sel = SW'($urandom_range(1, 15));
          cti = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
          got = 1'b0;
          ok_ack = 1'b0;
          for (int w = 0; w < 3000 && !got && !aborted; w++) begin
            @(negedge clk);
            if (m_ack_o[k] || m_err_o[k] || m_rty_o[k]) begin
              got = 1'b1;
              ok_ack = m_ack_o[k];
            end
            @(posedge clk); #1;
            if (rst) aborted = 1'b1;
          end
          if (!got && !aborted) hung = 1'b1;
          if (!got || !ok_ack || aborted) stop = 1'b1;
        end
        cyc = 1'b0;
        stb = 1'b0;
        cti = '0;
        if (aborted) restart = 1'b1;
      end
      done = 1'b1;
    end
  end

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 10) return int'($urandom_range(0, 2));
    if (r < 16) return int'($urandom_range(3, 5));
    if (r < 18) return int'(TO);
    return 1000;
  endfunction

  // Slave: responds after a random number of stalled strobe cycles; 1000 means never
  int sw_cnt = 0;
  int sw_dly = 0;
  always begin
    int r;
    logic raw;
    @(posedge clk); #2;
    s_dat_i = $urandom;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    raw = |(grant_o & m_stb_i);
    if (raw) begin
      if (sw_cnt == sw_dly) begin
        r = int'($urandom_range(0, 9));
        if (r < 8) s_ack_i = 1'b1;
        else if (r == 8) s_err_i = 1'b1;
        else s_rty_i = 1'b1;
        sw_cnt = 0;
        sw_dly = pick_delay();
      end else begin
        sw_cnt++;
      end
    end else begin
      sw_cnt = 0;
      sw_dly = pick_delay();
      r = int'($urandom_range(0, 23));
      if (r == 0) s_ack_i = 1'b1;
      else if (r == 1) s_err_i = 1'b1;
      else if (r == 2) s_rty_i = 1'b1;
    end
  end

  // Reference: owner index, round-robin pointer and a stall-cycle count
  int owner = -1;
  int last  = NM - 1;
  int stall = 0;
  always begin
    obs_t e;
    logic stb, anyr, abrt;
    bit   found;
    int   j;
    @(posedge clk); #3;
    e = '0;
    e.mdat = s_dat_i;
    if (rst) begin
      owner = -1;
      last  = NM - 1;
      stall = 0;
    end else if (owner >= 0) begin
      stb  = m_stb_i[owner];
      anyr = s_ack_i | s_err_i | s_rty_i;
      abrt = (TO != 0) && stb && (stall == int'(TO)) && !anyr;
      e.gnt[owner] = 1'b1;
      e.cyc  = m_cyc_i[owner] && !abrt;
      e.stb  = stb && !abrt;
      e.we   = m_we_i[owner];
      e.adr  = m_adr_i[owner*AW +: AW];
      e.sdat = m_dat_i[owner*DW +: DW];
      e.sel  = m_sel_i[owner*SW +: SW];
      e.cti  = m_cti_i[owner*3 +: 3];
      e.bte  = m_bte_i[owner*2 +: 2];
      if (e.stb) begin
        e.ack[owner] = s_ack_i;
        e.err[owner] = s_err_i;
        e.rty[owner] = s_rty_i;
      end
      if (abrt) begin
        e.err[owner] = 1'b1;
        e.to = 1'b1;
      end
      stall = (anyr || !e.stb) ? 0 : stall + 1;
      if (!m_cyc_i[owner]) owner = -1;
    end else begin
      stall = 0;
      found = 1'b0;
      for (int i = 1; i <= int'(NM); i++) begin
        j = (last + i) % int'(NM);
        if (!found && m_cyc_i[j]) begin
          found = 1'b1;
          owner = j;
          last  = j;
        end
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every cycle's outputs with the queued expectation
  always @(negedge clk) begin
    obs_t a, e;
    if (fin) begin
      n_tests++;
      if (rst_hit !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_window: busy cycle found=%0b, required 1", rst_hit);
      end
      n_tests++;
      if (rst_cyc_obs !== 1'b0 || rst_stb_obs !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_async_drop: cyc=%0b stb=%0b, required 0/0", rst_cyc_obs, rst_stb_obs);
      end
      n_tests++;
      if (rst_gnt_obs !== '0) begin
        n_fail++;
        $display("FAIL reset_grant: grant=%b, required 000", rst_gnt_obs);
      end
      n_tests++;
      if (all_done !== 1'b1) begin
        n_fail++;
        $display("FAIL traffic_done: done=%b, required 111", done_v);
      end
      n_tests++;
      if (hung_v !== '0) begin
        n_fail++;
        $display("FAIL response_wait: hung masters=%b, required 000", hung_v);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.gnt  = grant_o;
      a.cyc  = s_cyc_o;
      a.stb  = s_stb_o;
      a.we   = s_we_o;
      a.adr  = s_adr_o;
      a.sdat = s_dat_o;
      a.sel  = s_sel_o;
      a.cti  = s_cti_o;
      a.bte  = s_bte_o;
      a.ack  = m_ack_o;
      a.err  = m_err_o;
      a.rty  = m_rty_o;
      a.to   = timeout_o;
      a.mdat = m_dat_o;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t gnt=%b/%b cyc=%b/%b stb=%b/%b ack=%b/%b err=%b/%b rty=%b/%b to=%b/%b actual=%h required=%h",
                 $time, a.gnt, e.gnt, a.cyc, e.cyc, a.stb, e.stb, a.ack, e.ack, a.err, e.err,
                 a.rty, e.rty, a.to, e.to, a, e);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (400) @(posedge clk);
    for (int i = 0; i < 2000 && !rst_hit; i++) begin
      @(posedge clk); #2;
      if (grant_o != '0 && s_stb_o) rst_hit = 1'b1;
    end
    rst = 1'b1;
    #1;
    rst_cyc_obs = s_cyc_o;
    rst_stb_obs = s_stb_o;
    rst_gnt_obs = grant_o;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 40000 && !(&done_v); i++) @(posedge clk);
    all_done = &done_v;
    repeat (3) @(posedge clk);
    #1 fin = 1'b1;
  end

endmodule

// File: doc/wb_ext_mem_arbiter.md
# wb_ext_mem_arbiter

Parametrised N-master Wishbone arbiter with a response watchdog, driving the single external-memory Wishbone port of the SoC top.
- Replaces fixed point-to-point wiring of the external RAM port with round-robin arbitration across NUM_MASTERS initiators (OSD MAM, CPU memory port, future DMA).
- Adds per-cycle ownership tracking, a response-timeout abort that returns err, and a one-hot grant status vector for debug.

## Interface
Parameters:
- NUM_MASTERS, 2, number of Wishbone masters (1..8); index 0 has priority after reset.
- AW, 27, address width (matches external memory address width).
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 255, cycles with stb high and no ack/err/rty before abort; 0 disables watchdog.

Ports (clock and reset first):
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- m_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  master write data.
- m_sel_i  in  NUM_MASTERS*DW/8  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master control.
- m_cti_i  in  NUM_MASTERS*3; m_bte_i  in  NUM_MASTERS*2  burst tags.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master responses.
- s_adr_o  out  AW; s_dat_o  out  DW; s_sel_o  out  DW/8; s_we_o, s_cyc_o, s_stb_o  out  1; s_cti_o  out  3; s_bte_o  out  2  slave side.
- s_dat_i  in  DW; s_ack_i, s_err_i, s_rty_i  in  1  slave responses.
- grant_o  out  NUM_MASTERS  registered one-hot grant (all zero when idle).
- timeout_o  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, BUSY.
- IDLE: if any m_cyc_i high, grant first requester searching from (last+1) mod NUM_MASTERS upward, wrapping; register grant, last, go BUSY. No requester: stay IDLE.
- BUSY: slave outputs = granted master's signals (combinational mux on registered grant). Leave to IDLE when granted m_cyc_i low; grant_o clears same edge.
- Ungranted masters see ack/err/rty = 0 regardless of s_*_i; their requests wait, never dropped.
- Responses: m_ack_o[k] = s_ack_i & grant_o[k] & s_stb_o; same form for rty; m_err_o[k] also ORs watchdog abort. Responses arriving while s_stb_o low are discarded.
- Watchdog: counter cleared in IDLE, on any s_ack_i/s_err_i/s_rty_i, or when s_stb_o low; increments each BUSY cycle with s_stb_o high. On reaching TIMEOUT: that cycle m_err_o[granted]=1, timeout_o=1, s_cyc_o=s_stb_o=0, counter clears; state stays BUSY until master drops cyc.
- Burst tags passed through unmodified; grant held across the whole cyc, so bursts are never split.
- NUM_MASTERS=1: grant logic degenerates; behaviour identical apart from fixed index 0.

## Timing
- Reset (async assert, sync release): state IDLE, grant_o=0, last=NUM_MASTERS-1, counter 0; s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, m_rty_o, timeout_o all 0; s_adr_o/s_dat_o/s_sel_o/s_cti_o/s_bte_o = 0.
- Arbitration latency: m_cyc_i rises at edge t in IDLE -> grant_o and s_cyc_o high after edge t+1 (one cycle).
- Ack path combinational: s_ack_i -> m_ack_o zero-cycle.
- Release: granted cyc low at edge t -> IDLE after t; new grant earliest after t+1 (one dead cycle between owners).
- Simultaneous requests: round-robin order guaranteed; a continuously requesting master waits at most NUM_MASTERS-1 owner cycles.
- Ack and watchdog expiry same cycle: ack wins, counter clears, no err.
- Reset mid-transaction: s_cyc_o/s_stb_o drop asynchronously; no response issued to any master.

## Test plan
- Single master 0, read addr 0x100, slave acks 2 cycles later with 0xDEADBEEF -> grant_o=01 one cycle after cyc, m_ack_o=01, m_dat_o=0xDEADBEEF, grant_o=00 after cyc drops.
- Masters 0 and 1 raise cyc same cycle, each 1-beat, repeated 4x -> grants alternate 0,1,0,1 with one idle cycle between.
- Master 1 8-beat incrementing burst (cti=010 then 111) while master 0 requests -> all 8 acks to master 1, master 0 granted only after burst cyc drops.
- Slave never responds, TIMEOUT=16 -> m_err_o[granted] and timeout_o pulse exactly 16 cycles after stb asserted; s_stb_o low that cycle.
- s_ack_i on the exact timeout cycle -> ack delivered, no err, no timeout_o.
- Assert rst mid-burst -> s_cyc_o=0 immediately, grant_o=00; after release master 0 wins simultaneous request.
